// File: rtl/mem_pkg.sv
// Shared types for the core-to-RAM load/store controller.
// Size encodings, FSM states, latched request bundle and alignment check.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_e;

    typedef struct packed {
        logic       wen;
        logic [1:0] size;
        logic       sext;
        logic [1:0] off;
    } req_t;

    // Misaligned half/word or the reserved size code.
    function automatic logic req_bad(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a right-justified core view and a word RAM.
// Pure combinational: write mask, replicated store data, extended load data.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]         off,
    input  logic [1:0]         size,
    input  logic               wen,
    input  logic               sext,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH-1:0]   rdata_raw,
    output logic [WIDTH/8-1:0] wmask,
    output logic [WIDTH-1:0]   wdata_rep,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] sh;

    always_comb begin
        wmask     = '0;
        wdata_rep = wdata;
        rdata     = '0;
        sh        = rdata_raw >> {off, 3'b000};
        case (size)
            SZ_BYTE: begin
                wmask     = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                rdata     = {{24{sext & sh[7]}}, sh[7:0]};
            end
            SZ_HALF: begin
                wmask     = 4'b0011 << {off[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata     = {{16{sext & sh[15]}}, sh[15:0]};
            end
            SZ_WORD: begin
                wmask = 4'b1111;
                rdata = sh;
            end
            default: ;
        endcase
        if (!wen) wmask = '0;
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Single-outstanding load/store initiator for the 1-cycle-read SP RAM.
// Request latch, access FSM and registered RAM / response outputs.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [WIDTH-1:0]   req_addr_i,
    input  logic               req_wen_i,
    input  logic [1:0]         req_size_i,
    input  logic               req_sext_i,
    input  logic [WIDTH-1:0]   req_wdata_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [WIDTH-1:0]   rsp_rdata_o,
    output logic               rsp_err_o,
    output logic               mem_ena_o,
    output logic               mem_wen_o,
    output logic [WIDTH-1:0]   mem_addr_o,
    output logic [WIDTH/8-1:0] mem_wmask_o,
    output logic [WIDTH-1:0]   mem_data_o,
    input  logic [WIDTH-1:0]   mem_data_i
);

    state_e state_q, state_d;
    req_t   req_q, req_in, la_req;

    logic               acc;
    logic               bad;
    logic [WIDTH/8-1:0] la_wmask;
    logic [WIDTH-1:0]   la_wdata;
    logic [WIDTH-1:0]   la_rdata;

    assign req_ready_o = rst_n_i && (state_q == IDLE);
    assign acc         = req_valid_i && req_ready_o;
    assign bad         = req_bad(req_size_i, req_addr_i[1:0]);

    assign req_in = '{
        wen:  req_wen_i,
        size: req_size_i,
        sext: req_sext_i,
        off:  req_addr_i[1:0]
    };

    // Live inputs at acceptance, the latched copy afterwards.
    assign la_req = (state_q == IDLE) ? req_in : req_q;

    mem_lane_align #(
        .WIDTH (WIDTH)
    ) u_align (
        .off       (la_req.off),
        .size      (la_req.size),
        .wen       (la_req.wen),
        .sext      (la_req.sext),
        .wdata     (req_wdata_i),
        .rdata_raw (mem_data_i),
        .wmask     (la_wmask),
        .wdata_rep (la_wdata),
        .rdata     (la_rdata)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (acc) state_d = bad ? RESP : ACCESS;
            end
            ACCESS: state_d = req_q.wen ? RESP : WAIT;
            WAIT:   state_d = RESP;
            RESP: begin
                if (rsp_valid_o && rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_q       <= '0;
            mem_ena_o   <= 1'b0;
            mem_wen_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wmask_o <= '0;
            mem_data_o  <= '0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            mem_ena_o <= (state_d == ACCESS);
            mem_wen_o <= (state_d == ACCESS) && req_wen_i;
            if (acc) begin
                req_q       <= req_in;
                rsp_err_o   <= bad;
                rsp_rdata_o <= '0;
                if (!bad) begin
                    mem_addr_o  <= {req_addr_i[WIDTH-1:2], 2'b00};
                    mem_wmask_o <= la_wmask;
                    mem_data_o  <= la_wdata;
                end
            end
            if (state_q == WAIT) rsp_rdata_o <= la_rdata;
            // Valid follows entry into RESP by one edge.
            if (state_q == RESP && !rsp_valid_o)
                rsp_valid_o <= 1'b1;
            else if (rsp_valid_o && rsp_ready_i)
                rsp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural 1-cycle-read RAM.
// Checks latency, lane steering, errors, backpressure and mid-op reset.
module tb_mem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_wen = 1'b0;
    logic [1:0]  req_size = '0;
    logic        req_sext = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_ena;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_data;
    logic [31:0] ram_q = '0;

    logic [31:0] ram [16] = '{0: 32'h8001_1234, default: 32'h0};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ena) begin
            for (int b = 0; b < 4; b++)
                if (mem_wen && mem_wmask[b])
                    ram[mem_addr[5:2]][8*b +: 8] <= mem_data[8*b +: 8];
            ram_q <= ram[mem_addr[5:2]];
        end
    end

    mem_req_ctrl #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_wen_i   (req_wen),
        .req_size_i  (req_size),
        .req_sext_i  (req_sext),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .mem_ena_o   (mem_ena),
        .mem_wen_o   (mem_wen),
        .mem_addr_o  (mem_addr),
        .mem_wmask_o (mem_wmask),
        .mem_data_o  (mem_data),
        .mem_data_i  (ram_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge; returns at the negedge after E0.
    task automatic req(input logic wen, input logic [1:0] size,
                       input logic sext, input logic [31:0] addr,
                       input logic [31:0] wdata);
        req_wen   = wen;
        req_size  = size;
        req_sext  = sext;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic complete(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_vld_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rdy_back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic load_chk(input string tag, input logic [1:0] size,
                            input logic sext, input logic [31:0] addr,
                            input logic [31:0] exp);
        req(1'b0, size, sext, addr, 32'h0);
        chk({tag, "_ena"}, 32'(mem_ena), 32'd1);
        chk({tag, "_wen"}, 32'(mem_wen), 32'd0);
        chk({tag, "_wmask"}, 32'(mem_wmask), 32'd0);
        chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
        @(negedge clk);
        chk({tag, "_vld_e1"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_vld_e2"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_vld_e3"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rdata"}, rsp_rdata, exp);
        chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_ena", 32'(mem_ena), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wmask", 32'(mem_wmask), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd1);

        // store word
        req(1'b1, 2'b10, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF);
        chk("sw_ena", 32'(mem_ena), 32'd1);
        chk("sw_wen", 32'(mem_wen), 32'd1);
        chk("sw_addr", mem_addr, 32'h8000_0004);
        chk("sw_wmask", 32'(mem_wmask), 32'hF);
        chk("sw_data", mem_data, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("sw_ena_off", 32'(mem_ena), 32'd0);
        chk("sw_vld_e1", 32'(rsp_valid), 32'd0);
        chk("sw_rdy_busy", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("sw_vld_e2", 32'(rsp_valid), 32'd1);
        chk("sw_err", 32'(rsp_err), 32'd0);
        chk("sw_rdata", rsp_rdata, 32'd0);
        chk("sw_ram", ram[1], 32'hDEAD_BEEF);
        complete("sw");

        // load half from 0x8001_1234 at offset 2
        load_chk("lh_s", 2'b01, 1'b1, 32'h8000_0002, 32'hFFFF_8001);
        complete("lh_s");
        load_chk("lh_u", 2'b01, 1'b0, 32'h8000_0002, 32'h0000_8001);
        complete("lh_u");

        // store byte to lane 3
        req(1'b1, 2'b00, 1'b0, 32'h8000_0003, 32'h0000_00A5);
        chk("sb_wmask", 32'(mem_wmask), 32'h8);
        chk("sb_data", mem_data, 32'hA5A5_A5A5);
        chk("sb_addr", mem_addr, 32'h8000_0000);
        @(negedge clk);
        @(negedge clk);
        chk("sb_vld_e2", 32'(rsp_valid), 32'd1);
        complete("sb");
        chk("sb_ram", ram[0], 32'hA501_1234);

        load_chk("lb_s", 2'b00, 1'b1, 32'h8000_0003, 32'hFFFF_FFA5);
        complete("lb_s");
        load_chk("lb_u", 2'b00, 1'b0, 32'h8000_0003, 32'h0000_00A5);
        complete("lb_u");

        // misaligned word and illegal size
        req(1'b0, 2'b10, 1'b0, 32'h8000_0002, 32'h0);
        chk("mis_ena", 32'(mem_ena), 32'd0);
        chk("mis_vld_e0", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("mis_vld_e1", 32'(rsp_valid), 32'd1);
        chk("mis_err", 32'(rsp_err), 32'd1);
        chk("mis_rdata", rsp_rdata, 32'd0);
        complete("mis");

        req(1'b1, 2'b11, 1'b0, 32'h8000_0000, 32'h1234_5678);
        chk("ill_ena", 32'(mem_ena), 32'd0);
        @(negedge clk);
        chk("ill_vld_e1", 32'(rsp_valid), 32'd1);
        chk("ill_err", 32'(rsp_err), 32'd1);
        complete("ill");
        chk("ill_ram", ram[0], 32'hA501_1234);

        // response backpressure with an intruding request
        load_chk("bp", 2'b01, 1'b1, 32'h8000_0002, 32'hFFFF_A501);
        req_wen   = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h8000_0008;
        req_wdata = 32'h1111_1111;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_vld", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, 32'hFFFF_A501);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_ena", 32'(mem_ena), 32'd0);
        end
        req_valid = 1'b0;
        complete("bp");
        chk("bp_ram", ram[2], 32'd0);

        // reset during ACCESS
        req(1'b0, 2'b00, 1'b1, 32'h8000_0003, 32'h0);
        chk("ra_ena", 32'(mem_ena), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("ra_ena_drop", 32'(mem_ena), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset during WAIT
        req(1'b0, 2'b00, 1'b1, 32'h8000_0003, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rw_vld", 32'(rsp_valid), 32'd0);
        chk("rw_ena", 32'(mem_ena), 32'd0);
        chk("rw_rdata", rsp_rdata, 32'd0);
        chk("rw_addr", mem_addr, 32'd0);
        chk("rw_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rw_no_rsp", 32'(rsp_valid), 32'd0);
        end
        load_chk("post", 2'b00, 1'b0, 32'h8000_0003, 32'h0000_00A5);
        complete("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
